oport_alloc: RTL and testbench
==============================

Name: oport_alloc

Overview:
- Per-output-port wormhole allocator and flow controller for the 5-port router.
- Arbitrates among the five input ports for one output port.
- Once a head flit wins, the output is locked to that input until its tail flit leaves.
- Tracks downstream buffer credits and gates every flit transfer on credit availability.
- Multicast/absorb requests take priority over ordinary unicast requests, matching the router's output mux control.

Parameters:
- PORTID, 0, index of the output port this instance serves (used only for debug/assertion labelling).
- DEPTH, 4, downstream buffer depth in flits; this is the initial and maximum credit count.
- CNTW, 3, credit counter width; must satisfy 2^CNTW > DEPTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_  input  1  reset; synchronous, active-low (`Enable_` = 0).
- req  input  5  req[i]=1: input i has a head flit routed to this output.
- mreq  input  5  mreq[i]=1: input i's request is multicast/absorb class (priority); ignored where req[i]=0.
- fvld  input  5  fvld[i]=1: input i presents a valid flit this cycle.
- ftail  input  5  ftail[i]=1: the flit presented by input i is a tail (a single-flit packet has head=tail).
- credit_in  input  1  downstream freed one buffer slot this cycle.
- sel  output  5  one-hot registered owner; drives the output mux select; 0 when idle.
- grt  output  5  one-hot pulse: the owner's flit is accepted this cycle; equals sel & {5{send}}.
- send  output  1  a flit crosses the output this cycle.
- credits  output  CNTW  current credit count.
- busy  output  1  allocator is in the LOCK state.
- ovf  output  1  sticky error flag: a credit returned while the count was already DEPTH.

Behaviour:
- Reset (rst_=0 at a clock edge, including mid-packet):
  - state=IDLE, sel=0, grt=0, send=0, busy=0.
  - credits=DEPTH, ovf=0.
  - RR pointer last=5'b00001, so input 1 has first priority.
  - Any in-flight packet is abandoned.
- State IDLE:
  - Eligible set E = req&mreq if |(req&mreq) is true, otherwise E = req.
  - If E is nonzero, pick a winner by round-robin: the first set bit of E scanning upward from the position after last, wrapping 4->0.
  - Next edge: sel<=winner, state<=LOCK.
  - Allocation costs 1 cycle. No flit is sent in IDLE. Allocation does not depend on credits.
- State LOCK:
  - send = |(sel & fvld) && credits != 0.
  - If send and |(sel & ftail): next edge state<=IDLE, sel<=0, last<=sel.
  - A non-tail send keeps the lock.
  - Requests from other inputs are ignored, including mreq.
  - If the owner drops fvld, the lock holds indefinitely.
- Credit update each edge: credits <= credits - send + credit_in.
  - If send and credit_in occur in the same cycle, the count is unchanged.
  - credit_in with credits==DEPTH and no send: count stays at DEPTH and ovf<=1.
  - credits never underflows, because send requires credits != 0.
- Throughput:
  - Back-to-back packets need 1 idle allocation cycle between tail and next head.
  - A single-flit packet: allocation at cycle N, send at cycle N+1, IDLE at N+2.
  - Sustained rate is 1 flit/cycle while credits > 0.
- req/mreq sampled in LOCK have no effect. After unlock, the round-robin pointer guarantees the previous owner has lowest priority within its class.

Decomposition:
- define.h already holds PORT (4), PORT_P1 (5), `Enable_` (0) and the MULTABS encoding; add OA_IDLE/OA_LOCK state encodings there.
- One combinational sub-module, rr_pick: inputs req[4:0] and last[4:0], output a one-hot winner.
  - It is distinct from arb because it has no internal state; the pointer lives in oport_alloc.

Test Plan:
- Reset, then req=5'b00100, fvld[2]=1 with 3 body flits then a tail -> sel=00100 one cycle later; send high 4 consecutive cycles; credits 4->0; busy drops after the tail.
- req=5'b10001 simultaneous, last=00001 after reset -> input 4 wins first (scan starts at bit 1); after its tail, input 0 wins.
- req=5'b00110, mreq=5'b00100 -> input 2 granted despite RR order; mid-packet mreq[1] assertion -> lock held, no switch.
- DEPTH=4, 6-flit packet, no credit_in -> send stalls after 4 flits with sel held; credit_in pulse -> exactly one more flit sent per credit.
- credits=DEPTH plus credit_in -> ovf=1 and remains 1 until reset; send and credit_in in the same cycle -> count unchanged.
- rst_=0 mid-packet (owner=3, credits=1) -> next cycle sel=0, credits=4, busy=0, grt=0, last=00001.

Source files
------------

// File: rtl/oport_alloc_pkg.sv
// -----------------------------------------------------------------------------
// oport_alloc_pkg
//   Shared types and constants for the per-output-port wormhole allocator.
//   - NP          : number of router input ports competing for one output
//   - port_vec_t  : one bit per input port
//   - oa_state_e  : allocator states (OA_IDLE / OA_LOCK)
//   - LAST_RST    : round-robin pointer value after reset (input 1 first)
//   - lowest_set  : isolate the least-significant set bit of a port vector
// -----------------------------------------------------------------------------
package oport_alloc_pkg;

   localparam int NP = 5;

   typedef logic [NP-1:0] port_vec_t;

   typedef enum logic {
      OA_IDLE = 1'b0,
      OA_LOCK = 1'b1
   } oa_state_e;

   localparam port_vec_t LAST_RST = 5'b00001;

   // Two's-complement trick: v & -v keeps only the lowest set bit.
   function automatic port_vec_t lowest_set(input port_vec_t v);
      return v & (~v + port_vec_t'(1));
   endfunction

endpackage

// File: rtl/oport_alloc_if.sv
// -----------------------------------------------------------------------------
// oport_alloc_if
//   Request/grant and credit bundle between the router's input side and one
//   output-port allocator.
//   master : drives req, mreq, fvld, ftail, credit_in; observes the results
//   slave  : the allocator; drives sel, grt, send, credits, busy, ovf
// -----------------------------------------------------------------------------
interface oport_alloc_if #(
   parameter int CNTW = 3
);
   import oport_alloc_pkg::*;

   port_vec_t        req;        // head flit routed to this output, per input
   port_vec_t        mreq;       // multicast/absorb class, per input
   port_vec_t        fvld;       // valid flit presented, per input
   port_vec_t        ftail;      // presented flit is a tail, per input
   logic             credit_in;  // downstream freed one slot
   port_vec_t        sel;        // registered one-hot owner (output mux select)
   port_vec_t        grt;        // owner's flit accepted this cycle
   logic             send;       // a flit crosses the output this cycle
   logic [CNTW-1:0]  credits;    // current downstream credit count
   logic             busy;       // allocator locked to an owner
   logic             ovf;        // sticky credit overflow

   modport master (
      output req, mreq, fvld, ftail, credit_in,
      input  sel, grt, send, credits, busy, ovf
   );

   modport slave (
      input  req, mreq, fvld, ftail, credit_in,
      output sel, grt, send, credits, busy, ovf
   );

endinterface

// File: rtl/oport_alloc_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Stateless round-robin picker. Returns the first set bit of req found by
//   scanning upward from the position just above the one-hot pointer last,
//   wrapping from bit 4 back to bit 0.
//   req  : candidate inputs
//   last : one-hot previous winner (lowest priority)
//   win  : one-hot winner, 0 when req is 0
// -----------------------------------------------------------------------------
module rr_pick
   import oport_alloc_pkg::*;
(
   input  port_vec_t req,
   input  port_vec_t last,
   output port_vec_t win
);

   port_vec_t w_hi;

   always_comb begin
      // Candidates strictly above the pointer win first; otherwise wrap and
      // take the lowest candidate overall (which includes last itself).
      w_hi = req & ~(last | (last - port_vec_t'(1)));
      win  = (w_hi != '0) ? lowest_set(w_hi) : lowest_set(req);
   end

endmodule

// File: rtl/oport_alloc.sv
// -----------------------------------------------------------------------------
// oport_alloc
//   Wormhole allocator and credit flow controller for one router output port.
//   In IDLE it picks an input round-robin (multicast/absorb class first) and
//   locks onto it; in LOCK it forwards the owner's flits while credits remain
//   and releases the lock when the tail flit leaves.
//   clk  : rising-edge clock
//   rst_ : synchronous, active-low reset
//   bus  : oport_alloc_if.slave (requests, flit valid/tail, credit return,
//          sel/grt/send/credits/busy/ovf)
// -----------------------------------------------------------------------------
module oport_alloc
   import oport_alloc_pkg::*;
#(
   parameter int PORTID = 0,
   parameter int DEPTH  = 4,
   parameter int CNTW   = 3
)(
   input  logic           clk,
   input  logic           rst_,
   oport_alloc_if.slave   bus
);

   localparam logic [CNTW-1:0] CMAX = CNTW'(DEPTH);

   oa_state_e        r_state;
   oa_state_e        w_state_nxt;
   port_vec_t        r_sel;
   port_vec_t        r_last;
   logic [CNTW-1:0]  r_credits;
   logic             r_ovf;

   port_vec_t        w_mc;
   port_vec_t        w_elig;
   port_vec_t        w_win;
   logic             w_send;
   logic             w_tail;

   // Priority class filter: any multicast/absorb request hides unicast ones.
   always_comb begin
      w_mc   = bus.req & bus.mreq;
      w_elig = (w_mc != '0) ? w_mc : bus.req;
   end

   rr_pick u_rr_pick (
      .req  (w_elig),
      .last (r_last),
      .win  (w_win)
   );

   // ---------------- state register ----------------
   // NOTE: reset is synchronous here, so it is tested inside the clocked
   // branch rather than listed in the sensitivity list.
   always_ff @(posedge clk) begin
      if (!rst_) r_state <= OA_IDLE;
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of process order.
      else       r_state <= w_state_nxt;
   end

   // ---------------- next-state logic ----------------
   // NOTE: the default assignment first keeps this block free of latches.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         OA_IDLE: if (w_elig != '0)     w_state_nxt = OA_LOCK;
         OA_LOCK: if (w_send && w_tail) w_state_nxt = OA_IDLE;
      endcase
   end

   // ---------------- output logic ----------------
   always_comb begin
      w_send = 1'b0;
      if (r_state == OA_LOCK)
         w_send = ((r_sel & bus.fvld) != '0) && (r_credits != '0);
      w_tail = (r_sel & bus.ftail) != '0;
   end

   assign bus.send    = w_send;
   assign bus.grt     = r_sel & {NP{w_send}};
   assign bus.sel     = r_sel;
   assign bus.busy    = (r_state == OA_LOCK);
   assign bus.credits = r_credits;
   assign bus.ovf     = r_ovf;

   // ---------------- owner and round-robin pointer ----------------
   always_ff @(posedge clk) begin
      if (!rst_) begin
         r_sel  <= '0;
         r_last <= LAST_RST;
      end else if (r_state == OA_IDLE) begin
         if (w_elig != '0) r_sel <= w_win;
      end else if (w_send && w_tail) begin
         r_sel  <= '0;
         r_last <= r_sel;
      end
   end

   // ---------------- downstream credits ----------------
   always_ff @(posedge clk) begin
      if (!rst_) begin
         r_credits <= CMAX;
         r_ovf     <= 1'b0;
      end else begin
         case ({w_send, bus.credit_in})
            2'b10: r_credits <= r_credits - CNTW'(1);
            2'b01: begin
               // A return into a full counter is a protocol error: hold and flag.
               if (r_credits == CMAX) r_ovf     <= 1'b1;
               else                   r_credits <= r_credits + CNTW'(1);
            end
            default: ;  // idle, or send and return cancel out
         endcase
      end
   end

   a_sel_onehot : assert property (@(posedge clk) disable iff (!rst_)
                                   $onehot0(r_sel) && (r_credits <= CMAX))
      else $error("oport_alloc[%0d]: sel not one-hot or credits above depth", PORTID);

endmodule

// File: tb/tb_oport_alloc.sv
// -----------------------------------------------------------------------------
// tb_oport_alloc
//   Directed scenarios with literal expectations, then randomized traffic.
//   A behavioural model (owner index, pointer index, integer credit count)
//   predicts sel/grt/send/credits/busy/ovf every cycle.
// -----------------------------------------------------------------------------
module tb_oport_alloc;
   import oport_alloc_pkg::*;

   localparam int DEPTH = 4;
   localparam int CNTW  = 3;

   logic clk  = 1'b0;
   logic rst_ = 1'b0;

   oport_alloc_if #(.CNTW(CNTW)) bus ();

   oport_alloc #(.PORTID(0), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
      .clk  (clk),
      .rst_ (rst_),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit         m_valid = 1'b0;
   int         m_owner = -1;      // -1 when no input holds the output
   int         m_last  = 0;       // index of the previous owner
   int         m_cred  = DEPTH;
   bit         m_ovf   = 1'b0;
   logic [4:0] e_sel, e_grt, m_elig;
   bit         e_send, e_tail;

   always @(negedge clk) begin
      e_sel  = (m_owner >= 0) ? (5'd1 << m_owner) : 5'd0;
      e_send = (m_owner >= 0) && ((bus.fvld & e_sel) != 0) && (m_cred > 0);
      e_tail = (bus.ftail & e_sel) != 0;
      e_grt  = e_send ? e_sel : 5'd0;
      if (m_valid) begin
         check("sel",     32'(bus.sel),     32'(e_sel));
         check("grt",     32'(bus.grt),     32'(e_grt));
         check("send",    32'(bus.send),    32'(e_send));
         check("credits", 32'(bus.credits), 32'(m_cred));
         check("busy",    32'(bus.busy),    32'(m_owner >= 0));
         check("ovf",     32'(bus.ovf),     32'(m_ovf));
      end
      if (!rst_) begin
         m_valid = 1'b1;
         m_owner = -1;
         m_last  = 0;
         m_cred  = DEPTH;
         m_ovf   = 1'b0;
      end else begin
         if (e_send && !bus.credit_in) m_cred--;
         else if (!e_send && bus.credit_in) begin
            if (m_cred == DEPTH) m_ovf = 1'b1;
            else                 m_cred++;
         end
         if (m_owner < 0) begin
            m_elig = bus.req & bus.mreq;
            if (m_elig == 0) m_elig = bus.req;
            for (int k = 1; k <= NP; k++) begin
               int idx;
               idx = (m_last + k) % NP;
               if (m_owner < 0 && ((m_elig >> idx) & 5'd1) != 0) m_owner = idx;
            end
         end else if (e_send && e_tail) begin
            m_last  = m_owner;
            m_owner = -1;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic [4:0] rq, input logic [4:0] mq, input logic [4:0] fv,
                        input logic [4:0] ft, input logic ci);
      bus.req       = rq;
      bus.mreq      = mq;
      bus.fvld      = fv;
      bus.ftail     = ft;
      bus.credit_in = ci;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_ = 1'b0;
      drive(5'b0, 5'b0, 5'b0, 5'b0, 1'b0);
      tick();
      rst_ = 1'b1;
   endtask

   initial begin
      drive(5'b0, 5'b0, 5'b0, 5'b0, 1'b0);
      tick();
      tick();

      // Four-flit packet from input 2.
      do_reset();
      drive(5'b00100, 5'b0, 5'b00100, 5'b0, 1'b0);
      @(negedge clk);
      check("rst_sel",     32'(bus.sel), 32'h0);
      check("rst_busy",    32'(bus.busy), 32'h0);
      check("rst_credits", 32'(bus.credits), 32'd4);
      check("rst_ovf",     32'(bus.ovf), 32'h0);
      check("idle_nosend", 32'(bus.send), 32'h0);
      tick();
      @(negedge clk);
      check("t1_sel", 32'(bus.sel), 32'h04);
      check("t1_grt", 32'(bus.grt), 32'h04);
      tick();
      @(negedge clk);
      check("t1_cred3", 32'(bus.credits), 32'd3);
      tick();
      tick();
      drive(5'b00100, 5'b0, 5'b00100, 5'b00100, 1'b0);
      @(negedge clk);
      check("t1_tail_send", 32'(bus.send), 32'h1);
      check("t1_cred1",     32'(bus.credits), 32'd1);
      tick();
      drive(5'b0, 5'b0, 5'b0, 5'b0, 1'b0);
      @(negedge clk);
      check("t1_unbusy", 32'(bus.busy), 32'h0);
      check("t1_cred0",  32'(bus.credits), 32'd0);
      for (int i = 0; i < 4; i++) begin
         drive(5'b0, 5'b0, 5'b0, 5'b0, 1'b1);
         tick();
      end
      drive(5'b0, 5'b0, 5'b0, 5'b0, 1'b0);
      @(negedge clk);
      check("t1_refill", 32'(bus.credits), 32'd4);

      // Round-robin from reset pointer: input 4 before input 0.
      do_reset();
      drive(5'b10001, 5'b0, 5'b10001, 5'b10001, 1'b0);
      tick();
      @(negedge clk);
      check("rr_first", 32'(bus.sel), 32'h10);
      tick();
      @(negedge clk);
      check("rr_gap", 32'(bus.sel), 32'h00);
      tick();
      @(negedge clk);
      check("rr_second", 32'(bus.sel), 32'h01);
      tick();
      drive(5'b0, 5'b0, 5'b0, 5'b0, 1'b0);

      // Multicast class priority and lock hold against a new mreq.
      do_reset();
      drive(5'b00110, 5'b00100, 5'b00110, 5'b0, 1'b0);
      tick();
      @(negedge clk);
      check("mreq_prio", 32'(bus.sel), 32'h04);
      drive(5'b00110, 5'b00010, 5'b00110, 5'b0, 1'b0);
      tick();
      @(negedge clk);
      check("lock_hold", 32'(bus.sel), 32'h04);
      tick();
      drive(5'b00110, 5'b00010, 5'b00110, 5'b00100, 1'b0);
      tick();
      drive(5'b0, 5'b0, 5'b0, 5'b0, 1'b0);

      // Six-flit packet with only four credits.
      do_reset();
      drive(5'b01000, 5'b0, 5'b01000, 5'b0, 1'b0);
      for (int i = 0; i < 5; i++) tick();
      @(negedge clk);
      check("stall_send", 32'(bus.send), 32'h0);
      check("stall_sel",  32'(bus.sel), 32'h08);
      tick();
      drive(5'b01000, 5'b0, 5'b01000, 5'b0, 1'b1);
      tick();
      drive(5'b01000, 5'b0, 5'b01000, 5'b0, 1'b0);
      @(negedge clk);
      check("credit_resume", 32'(bus.send), 32'h1);
      tick();
      @(negedge clk);
      check("credit_one_only", 32'(bus.send), 32'h0);
      drive(5'b01000, 5'b0, 5'b01000, 5'b0, 1'b1);
      tick();
      drive(5'b01000, 5'b0, 5'b01000, 5'b01000, 1'b0);
      tick();
      drive(5'b0, 5'b0, 5'b0, 5'b0, 1'b0);
      @(negedge clk);
      check("t4_unbusy", 32'(bus.busy), 32'h0);

      // Overflow, then send and credit return in the same cycle.
      do_reset();
      drive(5'b0, 5'b0, 5'b0, 5'b0, 1'b1);
      tick();
      drive(5'b0, 5'b0, 5'b0, 5'b0, 1'b0);
      @(negedge clk);
      check("ovf_set",  32'(bus.ovf), 32'h1);
      check("ovf_cred", 32'(bus.credits), 32'd4);
      drive(5'b00001, 5'b0, 5'b00001, 5'b00001, 1'b0);
      tick();
      drive(5'b00001, 5'b0, 5'b00001, 5'b00001, 1'b1);
      tick();
      drive(5'b0, 5'b0, 5'b0, 5'b0, 1'b0);
      @(negedge clk);
      check("send_plus_credit", 32'(bus.credits), 32'd4);
      check("ovf_sticky",       32'(bus.ovf), 32'h1);

      // Reset in the middle of a packet from input 3 with one credit left.
      do_reset();
      drive(5'b00010, 5'b0, 5'b00010, 5'b00010, 1'b0);
      tick();
      tick();
      drive(5'b01000, 5'b0, 5'b01000, 5'b0, 1'b0);
      tick();
      tick();
      tick();
      @(negedge clk);
      check("mid_owner", 32'(bus.sel), 32'h08);
      check("mid_cred",  32'(bus.credits), 32'd1);
      rst_ = 1'b0;
      tick();
      rst_ = 1'b1;
      drive(5'b0, 5'b0, 5'b0, 5'b0, 1'b0);
      @(negedge clk);
      check("mr_sel",  32'(bus.sel), 32'h0);
      check("mr_cred", 32'(bus.credits), 32'd4);
      check("mr_busy", 32'(bus.busy), 32'h0);
      check("mr_grt",  32'(bus.grt), 32'h0);
      drive(5'b00011, 5'b0, 5'b0, 5'b0, 1'b0);
      tick();
      @(negedge clk);
      check("mr_last", 32'(bus.sel), 32'h02);

      // Randomized traffic against the model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         rst_ = ($urandom_range(0, 249) != 0);
         drive(5'($urandom), 5'($urandom & $urandom), 5'($urandom | $urandom),
               5'($urandom & $urandom), ($urandom_range(0, 2) == 0));
         tick();
      end
      rst_ = 1'b1;
      drive(5'b0, 5'b0, 5'b0, 5'b0, 1'b0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
